// File: rtl/nn_pkg.sv
// Types shared by the inference controller and the neural network datapath.
package nn_pkg;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_RELU,
        ACT_SIGMOID,
        ACT_TANH
    } ACTIVATION;

    typedef struct packed {
        logic [15:0] num_inputs;
        logic [15:0] num_neurons;
        ACTIVATION   activation;
    } LAYER;

    typedef enum logic [2:0] {
        LOAD,
        FIRE,
        WAIT,
        SCAN,
        RESULT
    } ctrl_state_t;

endpackage

// File: rtl/argmax_unit.sv
// Sequential signed argmax: one element per cycle, starting with element 0 in the start cycle.
// done is a combinational strobe in the last compare cycle; index/score then hold the final answer.
module argmax_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_OUTPUTS = 10,
    localparam int IDX_W      = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0]  vec,
    output logic                                    done,
    output logic [IDX_W-1:0]                        index,
    output logic signed [DATA_WIDTH-1:0]            score
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OUTPUTS - 1);

    logic                         running;
    logic [IDX_W-1:0]             pos;
    logic [IDX_W-1:0]             best_idx;
    logic signed [DATA_WIDTH-1:0] best_val;
    logic signed [DATA_WIDTH-1:0] cur;
    logic                         take;

    // Strictly greater only, so ties keep the lowest index.
    assign cur   = vec[pos];
    assign take  = cur > best_val;
    assign done  = running && (pos == LAST);
    assign index = take ? pos : best_idx;
    assign score = take ? cur : best_val;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            running  <= 1'b0;
            pos      <= '0;
            best_idx <= '0;
            best_val <= '0;
        end else if (start) begin
            running  <= 1'b1;
            pos      <= IDX_W'(1);
            best_idx <= '0;
            best_val <= vec[0];
        end else if (running) begin
            best_idx <= index;
            best_val <= score;
            if (pos == LAST) begin
                running <= 1'b0;
            end else begin
                pos <= pos + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nn_inference_controller.sv
// Loads a serial vector, fires the network, waits (with timeout) for a fresh done edge, argmaxes the outputs.
// Input stream is back-pressured outside LOAD; the result is held until result_ready.
module nn_inference_controller
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_INPUTS     = 10,
    parameter int NUM_OUTPUTS    = 10,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int CLASS_W       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1,
    localparam int IDX_W         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    localparam int TCNT_W        = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   in_valid,
    input  logic signed [DATA_WIDTH-1:0]           in_data,
    input  logic                                   in_last,
    output logic                                   in_ready,
    output logic                                   nn_inputs_ready,
    output logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  nn_inputs,
    input  logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] nn_outputs,
    input  logic                                   nn_outputs_ready,
    output logic                                   result_valid,
    input  logic                                   result_ready,
    output logic [CLASS_W-1:0]                     result_class,
    output logic signed [DATA_WIDTH-1:0]           result_score,
    output logic                                   busy,
    output logic                                   err_framing,
    output logic                                   err_timeout
);

    localparam logic [IDX_W-1:0]  LAST_IN   = IDX_W'(NUM_INPUTS - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_t                            state;
    logic [IDX_W-1:0]                       idx;
    logic [TCNT_W-1:0]                      tcnt;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  in_buf;
    logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] out_buf;
    logic                                   ready_q;
    logic                                   scan_start;
    logic                                   am_done;
    logic [CLASS_W-1:0]                     am_index;
    logic signed [DATA_WIDTH-1:0]           am_score;

    assign nn_inputs = in_buf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= LOAD;
            idx             <= '0;
            tcnt            <= '0;
            in_buf          <= '0;
            out_buf         <= '0;
            ready_q         <= 1'b0;
            scan_start      <= 1'b0;
            in_ready        <= 1'b1;
            busy            <= 1'b0;
            nn_inputs_ready <= 1'b0;
            result_valid    <= 1'b0;
            result_class    <= '0;
            result_score    <= '0;
            err_framing     <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            ready_q         <= nn_outputs_ready;
            nn_inputs_ready <= 1'b0;
            scan_start      <= 1'b0;
            err_framing     <= 1'b0;
            err_timeout     <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        in_buf[idx] <= in_data;
                        if (in_last && idx == LAST_IN) begin
                            state           <= FIRE;
                            idx             <= '0;
                            nn_inputs_ready <= 1'b1;
                            in_ready        <= 1'b0;
                            busy            <= 1'b1;
                        end else if (in_last || idx == LAST_IN) begin
                            err_framing <= 1'b1;
                            idx         <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    state <= WAIT;
                    tcnt  <= '0;
                end
                WAIT: begin
                    // A level left high by the previous inference is not a completion.
                    if (nn_outputs_ready && !ready_q) begin
                        out_buf    <= nn_outputs;
                        scan_start <= 1'b1;
                        state      <= SCAN;
                    end else if (tcnt == TCNT_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= LOAD;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                SCAN: begin
                    if (am_done) begin
                        result_valid <= 1'b1;
                        result_class <= am_index;
                        result_score <= am_score;
                        state        <= RESULT;
                    end
                end
                RESULT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= LOAD;
                        in_ready     <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state    <= LOAD;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    argmax_unit #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_OUTPUTS (NUM_OUTPUTS)
    ) u_argmax (
        .clock (clock),
        .reset (reset),
        .start (scan_start),
        .vec   (out_buf),
        .done  (am_done),
        .index (am_index),
        .score (am_score)
    );

endmodule

// File: tb/tb_nn_inference_controller.sv
// Directed bench for nn_inference_controller; the network is a stub driven from the test tasks.
module tb_nn_inference_controller;

    localparam int DW = 32;
    localparam int NI = 10;
    localparam int NO = 10;
    localparam int TO = 8;

    typedef int vec_t [NO];

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_last;
    logic                 in_ready;
    logic                 nn_inputs_ready;
    logic [NI-1:0][DW-1:0] nn_inputs;
    logic [NO-1:0][DW-1:0] nn_outputs;
    logic                 nn_outputs_ready;
    logic                 result_valid;
    logic                 result_ready;
    logic [3:0]           result_class;
    logic signed [DW-1:0] result_score;
    logic                 busy;
    logic                 err_framing;
    logic                 err_timeout;

    int vectors = 0;
    int miscompares = 0;
    int fire_cnt = 0;
    int framing_cnt = 0;
    int timeout_cnt = 0;

    nn_inference_controller #(
        .DATA_WIDTH     (DW),
        .NUM_INPUTS     (NI),
        .NUM_OUTPUTS    (NO),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .nn_inputs_ready  (nn_inputs_ready),
        .nn_inputs        (nn_inputs),
        .nn_outputs       (nn_outputs),
        .nn_outputs_ready (nn_outputs_ready),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_class     (result_class),
        .result_score     (result_score),
        .busy             (busy),
        .err_framing      (err_framing),
        .err_timeout      (err_timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (nn_inputs_ready) fire_cnt++;
        if (err_framing) framing_cnt++;
        if (err_timeout) timeout_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_vector(input int n, input int last_pos, input int base, output bit ok);
        ok = 1'b1;
        for (int e = 0; e < n; e++) begin
            int guard;
            guard = 0;
            in_valid = 1'b1;
            in_data  = base + e;
            in_last  = (e == last_pos);
            while (!in_ready && guard < 100) begin
                @(negedge clock);
                guard++;
            end
            if (guard >= 100) ok = 1'b0;
            @(negedge clock);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic set_outputs(input vec_t v);
        for (int i = 0; i < NO; i++) nn_outputs[i] = v[i];
    endtask

    task automatic wait_result(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (result_valid) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || nn_inputs_ready !== 1'b0 || result_valid !== 1'b0 ||
            err_framing !== 1'b0 || err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: in_ready=%b busy=%b fire=%b valid=%b efr=%b eto=%b (want 1 0 0 0 0 0)",
                     in_ready, busy, nn_inputs_ready, result_valid, err_framing, err_timeout);
        end
        vectors++;
        if (result_class !== 4'd0 || result_score !== 0 || nn_inputs !== '0) begin
            miscompares++;
            $display("FAIL reset_data: class=%0d score=%0d inputs=%h (want all 0)", result_class, result_score, nn_inputs);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_nominal;
        vec_t vals = '{0, 3, 9, 2, 9, -7, 4, 8, -1, 5};
        logic [NI-1:0][DW-1:0] exp_in;
        bit ok;
        int c;
        int f0;
        f0 = fire_cnt;
        for (int i = 0; i < NI; i++) exp_in[i] = i + 1;
        send_vector(10, 9, 1, ok);
        vectors++;
        if (!ok || nn_inputs_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL nom_fire: ok=%0d nn_inputs_ready=%b (want 1 1 the cycle after last)", ok, nn_inputs_ready);
        end
        vectors++;
        if (nn_inputs !== exp_in) begin
            miscompares++;
            $display("FAIL nom_inputs: got %h want %h", nn_inputs, exp_in);
        end
        repeat (5) @(negedge clock);
        set_outputs(vals);
        nn_outputs_ready = 1'b1;
        wait_result(c);
        vectors++;
        if (c != 11) begin
            miscompares++;
            $display("FAIL nom_latency: result_valid after %0d cycles, want 11", c);
        end
        vectors++;
        if (result_class !== 4'd2 || result_score !== 9) begin
            miscompares++;
            $display("FAIL nom_result: class=%0d score=%0d want 2 9", result_class, result_score);
        end
        vectors++;
        if (fire_cnt - f0 != 1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL nom_pulse: fire pulses=%0d busy=%b in_ready=%b want 1 1 0", fire_cnt - f0, busy, in_ready);
        end
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
        vectors++;
        if (result_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL nom_accept: valid=%b in_ready=%b busy=%b want 0 1 0", result_valid, in_ready, busy);
        end
    endtask

    task automatic test_held_level_backpressure;
        vec_t vals = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -5};
        bit ok;
        int c;
        set_outputs(vals);
        send_vector(10, 9, 11, ok);
        vectors++;
        if (!ok || nn_inputs_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL held_fire: ok=%0d nn_inputs_ready=%b want 1 1", ok, nn_inputs_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            vectors++;
            if (result_valid !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL held_no_early: cycle %0d valid=%b busy=%b want 0 1", k, result_valid, busy);
            end
        end
        nn_outputs_ready = 1'b0;
        @(negedge clock);
        nn_outputs_ready = 1'b1;
        wait_result(c);
        vectors++;
        if (c != 11 || result_class !== 4'd0 || result_score !== -5) begin
            miscompares++;
            $display("FAIL held_result: lat=%0d class=%0d score=%0d want 11 0 -5", c, result_class, result_score);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            vectors++;
            if (result_valid !== 1'b1 || result_class !== 4'd0 || result_score !== -5 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold: cycle %0d valid=%b class=%0d score=%0d in_ready=%b want 1 0 -5 0",
                         k, result_valid, result_class, result_score, in_ready);
            end
        end
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
        vectors++;
        if (result_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_accept: valid=%b in_ready=%b want 0 1", result_valid, in_ready);
        end
    endtask

    task automatic test_framing;
        vec_t vals = '{7, -3, 12, 12, 0, 11, -20, 5, 12, 1};
        bit ok;
        int c;
        int f0;
        int fr0;
        nn_outputs_ready = 1'b0;
        f0 = fire_cnt;
        fr0 = framing_cnt;
        send_vector(4, 3, 100, ok);
        vectors++;
        if (err_framing !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_short: err_framing=%b in_ready=%b busy=%b want 1 1 0", err_framing, in_ready, busy);
        end
        @(negedge clock);
        vectors++;
        if (err_framing !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_pulse_width: err_framing=%b want 0", err_framing);
        end
        send_vector(10, -1, 200, ok);
        vectors++;
        if (err_framing !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_nolast: err_framing=%b want 1", err_framing);
        end
        @(negedge clock);
        vectors++;
        if (fire_cnt != f0 || framing_cnt - fr0 != 2) begin
            miscompares++;
            $display("FAIL frame_counts: fires=%0d framing pulses=%0d want 0 2", fire_cnt - f0, framing_cnt - fr0);
        end
        set_outputs(vals);
        result_ready = 1'b1;
        send_vector(10, 9, 1, ok);
        vectors++;
        if (!ok || nn_inputs_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_recover_fire: ok=%0d nn_inputs_ready=%b want 1 1", ok, nn_inputs_ready);
        end
        repeat (2) @(negedge clock);
        nn_outputs_ready = 1'b1;
        wait_result(c);
        vectors++;
        if (c != 11 || result_class !== 4'd2 || result_score !== 12) begin
            miscompares++;
            $display("FAIL frame_recover_result: lat=%0d class=%0d score=%0d want 11 2 12", c, result_class, result_score);
        end
        @(negedge clock);
        result_ready = 1'b0;
        vectors++;
        if (result_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_early_one_cycle: valid=%b in_ready=%b want 0 1", result_valid, in_ready);
        end
    endtask

    task automatic test_timeout;
        vec_t vals = '{-10, -9, -8, -7, -6, -5, -4, -3, -2, -1};
        bit ok;
        int c;
        int t0;
        nn_outputs_ready = 1'b0;
        t0 = timeout_cnt;
        send_vector(10, 9, 1, ok);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clock);
            vectors++;
            if (err_timeout !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL to_wait: wait cycle %0d err_timeout=%b busy=%b in_ready=%b want 0 1 0",
                         k, err_timeout, busy, in_ready);
            end
        end
        @(negedge clock);
        vectors++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL to_fire: err_timeout=%b busy=%b in_ready=%b valid=%b want 1 0 1 0",
                     err_timeout, busy, in_ready, result_valid);
        end
        @(negedge clock);
        vectors++;
        if (err_timeout !== 1'b0 || timeout_cnt - t0 != 1) begin
            miscompares++;
            $display("FAIL to_pulse: err_timeout=%b pulses=%0d want 0 1", err_timeout, timeout_cnt - t0);
        end
        set_outputs(vals);
        send_vector(10, 9, 1, ok);
        repeat (TO - 1) @(negedge clock);
        @(negedge clock);
        nn_outputs_ready = 1'b1;
        wait_result(c);
        vectors++;
        if (c != 11 || timeout_cnt - t0 != 1 || result_class !== 4'd9 || result_score !== -1) begin
            miscompares++;
            $display("FAIL to_boundary: lat=%0d timeouts=%0d class=%0d score=%0d want 11 1 9 -1",
                     c, timeout_cnt - t0, result_class, result_score);
        end
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        vec_t vals = '{0, 3, 9, 2, 9, -7, 4, 8, -1, 5};
        bit ok;
        int c;
        nn_outputs_ready = 1'b0;
        @(negedge clock);
        send_vector(10, 9, 1, ok);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_async: busy=%b in_ready=%b want 0 1", busy, in_ready);
        end
        @(negedge clock);
        vectors++;
        if (result_valid !== 1'b0 || nn_inputs_ready !== 1'b0 || err_framing !== 1'b0 || err_timeout !== 1'b0 ||
            result_class !== 4'd0 || result_score !== 0 || nn_inputs !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: valid=%b fire=%b efr=%b eto=%b class=%0d score=%0d inputs=%h want all 0",
                     result_valid, nn_inputs_ready, err_framing, err_timeout, result_class, result_score, nn_inputs);
        end
        reset = 1'b0;
        @(negedge clock);
        set_outputs(vals);
        send_vector(10, 9, 1, ok);
        repeat (3) @(negedge clock);
        nn_outputs_ready = 1'b1;
        wait_result(c);
        vectors++;
        if (c != 11 || result_class !== 4'd2 || result_score !== 9) begin
            miscompares++;
            $display("FAIL rst_recover: lat=%0d class=%0d score=%0d want 11 2 9", c, result_class, result_score);
        end
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        in_valid         = 1'b0;
        in_data          = '0;
        in_last          = 1'b0;
        nn_outputs       = '0;
        nn_outputs_ready = 1'b0;
        result_ready     = 1'b0;
        test_reset();
        test_nominal();
        test_held_level_backpressure();
        test_framing();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
